// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the byte-serialising RAM arbiter.
package ram_arb_pkg;

  localparam int LEN_W  = 2;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  // Byte count (1..4) to the length-minus-one field carried on req_len.
  function automatic logic [LEN_W-1:0] len_enc(input int unsigned nbytes);
    return LEN_W'(nbytes - 1);
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_arbiter.sv
// One-hot grant picker: round-robin from ptr, or fixed lowest-index priority
// when RAM_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign grant = req & (~req + NUM_CH'(1));
`else
  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  logic [NUM_CH-1:0] rot_req;
  logic [NUM_CH-1:0] rot_gnt;
  assign rot_req = NUM_CH'({req, req} >> ptr);
  assign rot_gnt = rot_req & (~rot_req + NUM_CH'(1));
  assign grant   = NUM_CH'(({rot_gnt, rot_gnt} << ptr) >> NUM_CH);
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Multi-channel arbiter serialising 1..4 byte requests onto a byte-wide RAM bus.
// Define RAM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        req_we,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*2-1:0]      req_len,
  input  logic [NUM_CH*32-1:0]     req_wdata,
  output logic [NUM_CH-1:0]        resp_valid,
  output logic [31:0]              resp_rdata,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [ADDR_W-1:0]        mem_a,
  output logic                     mem_wr,
  output logic                     busy
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e              state_reg, state_next;
  logic [PTR_W-1:0]    ptr_reg, ch_reg, gnt_idx;
  logic                we_reg, sel_we;
  logic [ADDR_W-1:0]   addr_reg, sel_addr, mem_a_reg;
  logic [LEN_W-1:0]    len_reg, cnt_reg, sel_len;
  logic [WORD_W-1:0]   wdata_reg, rdata_reg, sel_wdata;
  logic [NUM_CH-1:0]   grant;
  logic                issue, push, last_cap;
  logic                sr_vld_reg [RD_LAT];
  logic [LEN_W-1:0]    sr_idx_reg [RD_LAT];

  logic [ADDR_W-1:0]   ch_addr  [NUM_CH];
  logic [LEN_W-1:0]    ch_len   [NUM_CH];
  logic [WORD_W-1:0]   ch_wdata [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign ch_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign ch_len[gi]   = req_len[gi*LEN_W +: LEN_W];
    assign ch_wdata[gi] = req_wdata[gi*WORD_W +: WORD_W];
  end

  rr_arbiter #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_rr_arbiter (
    .req   (req_valid & {NUM_CH{rdy_in && (state_reg == IDLE)}}),
    .ptr   (ptr_reg),
    .grant (grant)
  );

  always_comb begin
    gnt_idx   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant[k]) begin
        gnt_idx   = PTR_W'(k);
        sel_we    = req_we[k];
        sel_addr  = ch_addr[k];
        sel_len   = ch_len[k];
        sel_wdata = ch_wdata[k];
      end
    end
  end

  assign issue    = (state_reg == ISSUE) && rdy_in;
  assign push     = issue && !we_reg;
  assign last_cap = sr_vld_reg[RD_LAT-1] && (sr_idx_reg[RD_LAT-1] == len_reg);

  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    resp_valid = '0;
    resp_rdata = '0;
    mem_a      = mem_a_reg;
    mem_wr     = 1'b0;
    mem_dout   = '0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (|grant) begin
          req_ready  = grant & {NUM_CH{rst_in}};
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (rdy_in) begin
          mem_a    = addr_reg + ADDR_W'(cnt_reg);
          mem_wr   = we_reg;
          mem_dout = we_reg ? BYTE_W'(wdata_reg >> (BYTE_W * cnt_reg)) : '0;
          if (cnt_reg == len_reg) state_next = we_reg ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (last_cap) state_next = DONE;
      end
      DONE: begin
        resp_valid = NUM_CH'(1) << ch_reg;
        resp_rdata = we_reg ? '0 : rdata_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      ch_reg    <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      mem_a_reg <= '0;
    end else begin
      state_reg <= state_next;
      mem_a_reg <= mem_a;
      if ((state_reg == IDLE) && (|grant)) begin
        ch_reg    <= gnt_idx;
        we_reg    <= sel_we;
        addr_reg  <= sel_addr;
        len_reg   <= sel_len;
        wdata_reg <= sel_wdata;
        cnt_reg   <= '0;
        rdata_reg <= '0;
      end
      if (issue) cnt_reg <= cnt_reg + LEN_W'(1);
      if (sr_vld_reg[RD_LAT-1])
        rdata_reg[BYTE_W*sr_idx_reg[RD_LAT-1] +: BYTE_W] <= mem_din;
      if (state_reg == DONE)
        ptr_reg <= (ch_reg == PTR_W'(NUM_CH-1)) ? '0 : ch_reg + PTR_W'(1);
    end
  end

  // Read-byte tracker runs every cycle so capture is independent of rdy_in.
  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_cap
    if (gi == 0) begin : g_head
      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          sr_vld_reg[gi] <= 1'b0;
          sr_idx_reg[gi] <= '0;
        end else begin
          sr_vld_reg[gi] <= push;
          sr_idx_reg[gi] <= cnt_reg;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          sr_vld_reg[gi] <= 1'b0;
          sr_idx_reg[gi] <= '0;
        end else begin
          sr_vld_reg[gi] <= sr_vld_reg[gi-1];
          sr_idx_reg[gi] <= sr_idx_reg[gi-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-level reference model plus directed and random traffic.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;
  localparam int RD_LAT = 1;

  logic                     clk_in = 1'b0;
  logic                     rst_in = 1'b0;
  logic                     rdy_in = 1'b0;
  logic [NUM_CH-1:0]        req_valid = '0;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH-1:0]        req_we = '0;
  logic [NUM_CH*ADDR_W-1:0] req_addr = '0;
  logic [NUM_CH*2-1:0]      req_len = '0;
  logic [NUM_CH*32-1:0]     req_wdata = '0;
  logic [NUM_CH-1:0]        resp_valid;
  logic [31:0]              resp_rdata;
  logic [7:0]               mem_din = '0;
  logic [7:0]               mem_dout;
  logic [ADDR_W-1:0]        mem_a;
  logic                     mem_wr;
  logic                     busy;

  ram_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // RAM model: unwritten locations read as a fixed address-derived pattern.
  logic [7:0]  ram [logic [31:0]];
  logic [31:0] a_pipe [RD_LAT];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (mem_wr) ram[mem_a] = mem_dout;
    for (int k = RD_LAT - 1; k > 0; k--) a_pipe[k] = a_pipe[k-1];
    a_pipe[0] = mem_a;
    mem_din <= ram_rd(a_pipe[RD_LAT-1]);
  end

  // Reference model: one transaction at a time, tracked by bytes issued and
  // cycles remaining until the response.
  bit          m_busy = 1'b0;
  bit          m_we;
  int          m_ptr = 0, m_ch, m_len, m_issued, m_tail, m_start, m_c;
  logic [31:0] m_addr, m_wdata, m_rdata, m_last_a = '0, m_exp_a;
  logic [NUM_CH-1:0] exp_ready;

  always @(negedge clk_in) begin
    if (!rst_in) begin
      chk("rst_outs", {req_ready, resp_valid, busy, mem_wr, mem_dout}, '0);
      chk("rst_rdata", resp_rdata, '0);
      chk("rst_mem_a", mem_a, '0);
      m_busy = 1'b0;
      m_ptr = 0;
      m_last_a = '0;
    end else if (!m_busy) begin
      exp_ready = '0;
      if (rdy_in && (|req_valid)) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        m_start = 0;
`else
        m_start = m_ptr;
`endif
        m_ch = -1;
        for (int k = 0; k < NUM_CH; k++) begin
          m_c = (m_start + k) % NUM_CH;
          if (m_ch < 0 && req_valid[m_c]) m_ch = m_c;
        end
        exp_ready[m_ch] = 1'b1;
        m_we     = req_we[m_ch];
        m_addr   = req_addr[m_ch*ADDR_W +: ADDR_W];
        m_len    = int'(req_len[m_ch*2 +: 2]);
        m_wdata  = req_wdata[m_ch*32 +: 32];
        m_busy   = 1'b1;
        m_issued = 0;
        m_tail   = 0;
        m_rdata  = '0;
        if (!m_we)
          for (int k = 0; k <= m_len; k++)
            m_rdata = m_rdata | ({24'b0, ram_rd(m_addr + 32'(k))} << (8 * k));
      end
      chk("req_ready", req_ready, exp_ready);
      chk("idle_busy", busy, 1'b0);
      chk("idle_outs", {mem_wr, resp_valid}, '0);
    end else if (m_issued <= m_len) begin
      chk("issue_ctl", {busy, req_ready, resp_valid}, {1'b1, {2*NUM_CH{1'b0}}});
      if (rdy_in) begin
        m_exp_a = m_addr + 32'(m_issued);
        chk("mem_a", mem_a, m_exp_a);
        chk("mem_wr", mem_wr, m_we);
        if (m_we) chk("mem_dout", mem_dout, (m_wdata >> (8 * m_issued)) & 32'hFF);
        m_last_a = m_exp_a;
        m_issued++;
        if (m_issued > m_len) m_tail = m_we ? 1 : RD_LAT + 1;
      end else begin
        chk("stall_wr", mem_wr, 1'b0);
        chk("stall_a_hold", mem_a, m_last_a);
      end
    end else begin
      m_tail--;
      chk("tail_ctl", {busy, mem_wr, req_ready}, {1'b1, 1'b0, {NUM_CH{1'b0}}});
      if (m_tail == 0) begin
        chk("resp_valid", resp_valid, NUM_CH'(1) << m_ch);
        chk("resp_rdata", resp_rdata, m_rdata);
        m_busy = 1'b0;
        m_ptr = (m_ch + 1) % NUM_CH;
      end else begin
        chk("resp_early", resp_valid, '0);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_req(input int ch, input logic we, input logic [31:0] addr,
                         input int nbytes, input logic [31:0] wdata);
    req_valid[ch]             = 1'b1;
    req_we[ch]                = we;
    req_addr[ch*ADDR_W +: ADDR_W] = addr;
    req_len[ch*2 +: 2]        = len_enc(nbytes);
    req_wdata[ch*32 +: 32]    = wdata;
  endtask

  task automatic wait_grant(input int ch, output int g);
    g = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk_in);
      if (req_ready[ch]) begin g = cyc; break; end
    end
    if (g < 0) timeout("grant_wait");
  endtask

  task automatic wait_any(output int ch);
    ch = -1;
    for (int n = 0; n < 60 && ch < 0; n++) begin
      @(negedge clk_in);
      for (int k = 0; k < NUM_CH; k++) if (req_ready[k]) ch = k;
    end
    if (ch < 0) timeout("any_grant_wait");
  endtask

  task automatic wait_resp(input int ch, output int r, output logic [31:0] d);
    r = -1;
    d = '0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk_in);
      if (resp_valid[ch]) begin r = cyc; d = resp_rdata; break; end
    end
    if (r < 0) timeout("resp_wait");
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk_in);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("idle_wait");
  endtask

  initial begin
    int g, r, gch;
    logic [31:0] d;
    logic [7:0]  wr_bytes [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [31:0] wrap_a [4]   = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    int          got_seq [4];
    int          exp_seq [4];
`ifdef RAM_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    ram[32'h200] = 8'h34; ram[32'h201] = 8'h12;
    ram[32'h300] = 8'h11; ram[32'h301] = 8'h22; ram[32'h302] = 8'h33; ram[32'h303] = 8'h44;

    repeat (3) next_cycle();
    rst_in = 1'b1;
    rdy_in = 1'b1;

    // Both channels held valid: grant order.
    set_req(0, 1'b0, 32'h0000_0010, 1, 32'h0);
    set_req(1, 1'b0, 32'h0000_0020, 1, 32'h0);
    for (int k = 0; k < 4; k++) wait_any(got_seq[k]);
    next_cycle();
    req_valid = '0;
    for (int k = 0; k < 4; k++) chk($sformatf("alt_grant%0d", k), 64'(got_seq[k]), 64'(exp_seq[k]));
    $display("txn alternation grants %0d %0d %0d %0d", got_seq[0], got_seq[1], got_seq[2], got_seq[3]);
    wait_idle();

    // Four-byte write on ch1.
    next_cycle();
    set_req(1, 1'b1, 32'h0000_0100, 4, 32'hDEAD_BEEF);
    wait_grant(1, g);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      if (k == 0) req_valid = '0;
      @(negedge clk_in);
      chk("wr_a", mem_a, 32'h100 + 32'(k));
      chk("wr_strobe", mem_wr, 1'b1);
      chk("wr_byte", mem_dout, wr_bytes[k]);
    end
    wait_resp(1, r, d);
    chk("wr_latency", 64'(r - g), 64'd5);
    $display("txn write ch1 addr=100 grant=%0d resp=%0d", g, r);

    // Two-byte read on ch0.
    next_cycle();
    set_req(0, 1'b0, 32'h0000_0200, 2, 32'h0);
    wait_grant(0, g);
    next_cycle();
    req_valid = '0;
    wait_resp(0, r, d);
    chk("rd2_latency", 64'(r - g), 64'd4);
    chk("rd2_data", d, 32'h0000_1234);
    $display("txn read ch0 addr=200 data=%08h grant=%0d resp=%0d", d, g, r);

    // Four-byte read with a 2-cycle rdy_in stall after the second byte.
    next_cycle();
    set_req(0, 1'b0, 32'h0000_0300, 4, 32'h0);
    wait_grant(0, g);
    next_cycle();
    req_valid = '0;
    next_cycle();
    next_cycle();
    rdy_in = 1'b0;
    @(negedge clk_in);
    chk("stall_a", mem_a, 32'h301);
    chk("stall_no_wr", mem_wr, 1'b0);
    next_cycle();
    next_cycle();
    rdy_in = 1'b1;
    wait_resp(0, r, d);
    chk("stall_latency", 64'(r - g), 64'd8);
    chk("stall_data", d, 32'h4433_2211);
    $display("txn stalled read ch0 addr=300 data=%08h grant=%0d resp=%0d", d, g, r);

    // Address wrap.
    next_cycle();
    set_req(1, 1'b0, 32'hFFFF_FFFE, 4, 32'h0);
    wait_grant(1, g);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      if (k == 0) req_valid = '0;
      @(negedge clk_in);
      chk("wrap_a", mem_a, wrap_a[k]);
      chk("wrap_no_wr", mem_wr, 1'b0);
    end
    wait_resp(1, r, d);
    chk("wrap_latency", 64'(r - g), 64'd6);
    chk("wrap_data", d, 32'h5B5A_A5A4);
    $display("txn wrap read ch1 data=%08h grant=%0d resp=%0d", d, g, r);

    // Reset in the middle of an issue burst.
    next_cycle();
    set_req(1, 1'b0, 32'h0000_0400, 4, 32'h0);
    wait_grant(1, g);
    next_cycle();
    req_valid = '0;
    next_cycle();
    rst_in = 1'b0;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_a", mem_a, '0);
    next_cycle();
    rst_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      chk("no_resp_after_rst", resp_valid, '0);
    end
    next_cycle();
    set_req(0, 1'b0, 32'h0000_0500, 1, 32'h0);
    set_req(1, 1'b0, 32'h0000_0600, 1, 32'h0);
    wait_any(gch);
    chk("post_rst_grant", 64'(gch), 64'd0);
    next_cycle();
    req_valid = '0;
    wait_idle();
    $display("txn reset mid-issue, next grant ch%0d", gch);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      next_cycle();
      rdy_in = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NUM_CH; c++) begin
        req_valid[c]                 = ($urandom_range(0, 1) == 1);
        req_we[c]                    = ($urandom_range(0, 1) == 1);
        req_addr[c*ADDR_W +: ADDR_W] = $urandom();
        req_len[c*2 +: 2]            = 2'($urandom_range(0, 3));
        req_wdata[c*32 +: 32]        = $urandom();
      end
    end
    next_cycle();
    req_valid = '0;
    rdy_in = 1'b1;
    wait_idle();
    $display("txn random phase complete");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
